// File: rtl/msrv32_iadder_arbiter_pkg.sv
// Shared encodings for the immediate-adder arbiter slice.
package msrv32_iadder_arbiter_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic PORT_BR = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/msrv32_rr_arb2.sv
// Two-way arbiter with round-robin or fixed priority and a last-grant register.
module msrv32_rr_arb2
  import msrv32_iadder_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant_valid,
  output logic grant
);

  logic last_grant;

  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = PORT_BR;
    if (valid0 && valid1)
      grant = FIXED_PRIO ? PORT_BR : ~last_grant;
    else if (valid1)
      grant = PORT_LS;
  end

  // Reset to PORT_LS so that port 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last_grant <= PORT_LS;
    else if (advance)
      last_grant <= grant;
  end

endmodule

// File: rtl/msrv32_iadder_arbiter.sv
// Shares one immediate adder between the branch unit and the load/store AGU,
// registering the sum into a one-entry valid/ready response slot.
module msrv32_iadder_arbiter
  import msrv32_iadder_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W      = 4,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             req0_valid_in,
  output logic             req0_ready_out,
  input  logic             req0_src_in,
  input  logic [31:0]      req0_pc_in,
  input  logic [31:0]      req0_rs1_in,
  input  logic [31:0]      req0_imm_in,
  input  logic [TAG_W-1:0] req0_tag_in,
  input  logic             req1_valid_in,
  output logic             req1_ready_out,
  input  logic             req1_src_in,
  input  logic [31:0]      req1_pc_in,
  input  logic [31:0]      req1_rs1_in,
  input  logic [31:0]      req1_imm_in,
  input  logic [TAG_W-1:0] req1_tag_in,
  output logic [31:0]      iadder_pc_out,
  output logic [31:0]      iadder_rs1_out,
  output logic             iadder_src_out,
  output logic [31:0]      iadder_imm_out,
  input  logic [31:0]      iadder_result_in,
  output logic             rsp_valid_out,
  input  logic             rsp_ready_in,
  output logic [31:0]      rsp_result_out,
  output logic             rsp_id_out,
  output logic [TAG_W-1:0] rsp_tag_out,
  output logic             rsp_misaligned_out
);

  state_t           state;
  logic             grant_valid;
  logic             grant;
  logic             sel1;
  logic             can_accept;
  logic             accept;
  logic [TAG_W-1:0] grant_tag;

  assign rsp_valid_out = (state == ST_FULL);
  assign can_accept    = (state == ST_EMPTY) | (rsp_valid_out & rsp_ready_in);
  assign accept        = can_accept & grant_valid & rst_in;

  msrv32_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk         (clk_in),
    .rst_n       (rst_in),
    .valid0      (req0_valid_in),
    .valid1      (req1_valid_in),
    .advance     (accept),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Ready is masked while reset is held so nothing is acknowledged that the
  // slot cannot capture.
  assign req0_ready_out = accept & (grant == PORT_BR);
  assign req1_ready_out = accept & (grant == PORT_LS);

  assign sel1           = grant_valid & (grant == PORT_LS);
  assign iadder_pc_out  = sel1 ? req1_pc_in  : req0_pc_in;
  assign iadder_rs1_out = sel1 ? req1_rs1_in : req0_rs1_in;
  assign iadder_src_out = sel1 ? req1_src_in : req0_src_in;
  assign iadder_imm_out = sel1 ? req1_imm_in : req0_imm_in;
  assign grant_tag      = sel1 ? req1_tag_in : req0_tag_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= ST_EMPTY;
      rsp_result_out     <= '0;
      rsp_id_out         <= PORT_BR;
      rsp_tag_out        <= '0;
      rsp_misaligned_out <= 1'b0;
    end else if (accept) begin
      state              <= ST_FULL;
      rsp_result_out     <= iadder_result_in;
      rsp_id_out         <= grant;
      rsp_tag_out        <= grant_tag;
      rsp_misaligned_out <= |iadder_result_in[1:0];
    end else if (rsp_valid_out && rsp_ready_in) begin
      state <= ST_EMPTY;
    end
  end

endmodule

// File: tb/tb_msrv32_iadder_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance, each with a
// behavioural adder closing the operand loop.
module tb_msrv32_iadder_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        req0_valid_in, req0_src_in;
  logic [31:0] req0_pc_in, req0_rs1_in, req0_imm_in;
  logic [3:0]  req0_tag_in;
  logic        req1_valid_in, req1_src_in;
  logic [31:0] req1_pc_in, req1_rs1_in, req1_imm_in;
  logic [3:0]  req1_tag_in;
  logic        rsp_ready_in;

  logic        rr_r0, rr_r1, rr_src, rr_valid, rr_id, rr_mis;
  logic [31:0] rr_pc, rr_rs1, rr_imm, rr_sum, rr_result;
  logic [3:0]  rr_tag;
  logic        fp_r0, fp_r1, fp_src, fp_valid, fp_id, fp_mis;
  logic [31:0] fp_pc, fp_rs1, fp_imm, fp_sum, fp_result;
  logic [3:0]  fp_tag;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_in = ~clk_in;

  assign rr_sum = (rr_src ? rr_rs1 : rr_pc) + rr_imm;
  assign fp_sum = (fp_src ? fp_rs1 : fp_pc) + fp_imm;

  msrv32_iadder_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b0)) dut_rr (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(rr_r0), .req0_src_in(req0_src_in),
    .req0_pc_in(req0_pc_in), .req0_rs1_in(req0_rs1_in), .req0_imm_in(req0_imm_in),
    .req0_tag_in(req0_tag_in),
    .req1_valid_in(req1_valid_in), .req1_ready_out(rr_r1), .req1_src_in(req1_src_in),
    .req1_pc_in(req1_pc_in), .req1_rs1_in(req1_rs1_in), .req1_imm_in(req1_imm_in),
    .req1_tag_in(req1_tag_in),
    .iadder_pc_out(rr_pc), .iadder_rs1_out(rr_rs1), .iadder_src_out(rr_src),
    .iadder_imm_out(rr_imm), .iadder_result_in(rr_sum),
    .rsp_valid_out(rr_valid), .rsp_ready_in(rsp_ready_in), .rsp_result_out(rr_result),
    .rsp_id_out(rr_id), .rsp_tag_out(rr_tag), .rsp_misaligned_out(rr_mis)
  );

  msrv32_iadder_arbiter #(.TAG_W(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_valid_in(req0_valid_in), .req0_ready_out(fp_r0), .req0_src_in(req0_src_in),
    .req0_pc_in(req0_pc_in), .req0_rs1_in(req0_rs1_in), .req0_imm_in(req0_imm_in),
    .req0_tag_in(req0_tag_in),
    .req1_valid_in(req1_valid_in), .req1_ready_out(fp_r1), .req1_src_in(req1_src_in),
    .req1_pc_in(req1_pc_in), .req1_rs1_in(req1_rs1_in), .req1_imm_in(req1_imm_in),
    .req1_tag_in(req1_tag_in),
    .iadder_pc_out(fp_pc), .iadder_rs1_out(fp_rs1), .iadder_src_out(fp_src),
    .iadder_imm_out(fp_imm), .iadder_result_in(fp_sum),
    .rsp_valid_out(fp_valid), .rsp_ready_in(rsp_ready_in), .rsp_result_out(fp_result),
    .rsp_id_out(fp_id), .rsp_tag_out(fp_tag), .rsp_misaligned_out(fp_mis)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic pulse_reset();
    rst_in = 1'b0;
    #3;
    rst_in = 1'b1;
  endtask

  initial begin
    rst_in        = 1'b0;
    req0_valid_in = 1'b1; req0_src_in = 1'b0;
    req0_pc_in    = 32'h0000_1000; req0_rs1_in = 32'h0; req0_imm_in = 32'h20;
    req0_tag_in   = 4'h5;
    req1_valid_in = 1'b1; req1_src_in = 1'b1;
    req1_pc_in    = 32'h0; req1_rs1_in = 32'h0000_2003; req1_imm_in = 32'h0;
    req1_tag_in   = 4'h9;
    rsp_ready_in  = 1'b1;

    // Reset held with both requests valid
    step();
    check_vec("rst_r0", rr_r0, 0);
    check_vec("rst_r1", rr_r1, 0);
    check_vec("rst_valid", rr_valid, 0);
    check_vec("rst_result", rr_result, 0);
    check_vec("rst_id", rr_id, 0);
    check_vec("rst_tag", rr_tag, 0);
    check_vec("rst_mis", rr_mis, 0);

    // Single request on port 0
    req1_valid_in = 1'b0;
    rst_in = 1'b1;
    #1;
    check_vec("single_r0", rr_r0, 1);
    check_vec("single_r1", rr_r1, 0);
    step();
    check_vec("single_valid", rr_valid, 1);
    check_vec("single_result", rr_result, 32'h0000_1020);
    check_vec("single_id", rr_id, 0);
    check_vec("single_tag", rr_tag, 4'h5);
    check_vec("single_mis", rr_mis, 0);

    // Conflict: fresh reset so port 0 wins first, then alternation
    req0_valid_in = 1'b0;
    pulse_reset();
    req0_valid_in = 1'b1;
    req1_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_vec("rr_r0", rr_r0, (i % 2 == 0) ? 1 : 0);
      check_vec("rr_r1", rr_r1, (i % 2 == 1) ? 1 : 0);
      step();
      check_vec("rr_valid", rr_valid, 1);
      check_vec("rr_id", rr_id, (i % 2 == 1) ? 1 : 0);
      check_vec("rr_result", rr_result, (i % 2 == 1) ? 32'h0000_2003 : 32'h0000_1020);
      check_vec("rr_mis", rr_mis, (i % 2 == 1) ? 1 : 0);
      check_vec("rr_tag", rr_tag, (i % 2 == 1) ? 4'h9 : 4'h5);
    end

    // Backpressure: slot holds port 1's response
    rsp_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec("bp_r0", rr_r0, 0);
      check_vec("bp_r1", rr_r1, 0);
      step();
      check_vec("bp_valid", rr_valid, 1);
      check_vec("bp_result", rr_result, 32'h0000_2003);
      check_vec("bp_id", rr_id, 1);
    end
    rsp_ready_in = 1'b1;
    #1;
    check_vec("refill_r0", rr_r0, 1);
    check_vec("refill_r1", rr_r1, 0);
    step();
    check_vec("refill_valid", rr_valid, 1);
    check_vec("refill_result", rr_result, 32'h0000_1020);
    check_vec("refill_id", rr_id, 0);

    // Wrap-around of the sum
    req1_valid_in = 1'b0;
    req0_pc_in    = 32'hFFFF_FFF0;
    #1;
    check_vec("wrap_r0", rr_r0, 1);
    step();
    check_vec("wrap_result", rr_result, 32'h0000_0010);
    check_vec("wrap_mis", rr_mis, 0);
    check_vec("wrap_valid", rr_valid, 1);

    // Drain with no request: valid drops, data holds
    req0_valid_in = 1'b0;
    step();
    check_vec("drain_valid", rr_valid, 0);
    check_vec("drain_result", rr_result, 32'h0000_0010);

    // Reset mid-transfer discards the pending response
    req0_valid_in = 1'b1;
    step();
    req0_valid_in = 1'b0;
    rsp_ready_in  = 1'b0;
    check_vec("mid_valid_pre", rr_valid, 1);
    rst_in = 1'b0;
    #1;
    check_vec("mid_valid", rr_valid, 0);
    check_vec("mid_result", rr_result, 0);
    rst_in = 1'b1;

    // Fixed priority: port 0 wins every conflict
    req0_pc_in    = 32'h0000_1000;
    req0_valid_in = 1'b1;
    req1_valid_in = 1'b1;
    rsp_ready_in  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_vec("fp_r0", fp_r0, 1);
      check_vec("fp_r1", fp_r1, 0);
      step();
      check_vec("fp_id", fp_id, 0);
    end
    check_vec("fp_valid", fp_valid, 1);
    check_vec("fp_result", fp_result, 32'h0000_1020);
    check_vec("fp_tag", fp_tag, 4'h5);
    check_vec("fp_mis", fp_mis, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msrv32_iadder_arbiter.md
Name: msrv32_iadder_arbiter

Overview:
Shares one immediate adder (pc/rs1 + imm) between two requesters: port 0 is the branch/jump target unit and port 1 is the load/store address generator. The block arbitrates round-robin, drives the adder operands, and registers the sum into a one-entry response slot with valid/ready handshake. It sits between the decode/issue logic and the adder instance.

Parameters:
TAG_W, 4, width of the requester tag passed through with each request
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins on a conflict

Ports:
clk_in  input  1  core clock
rst_in  input  1  asynchronous, active-low reset
req0_valid_in  input  1  port 0 request valid
req0_ready_out  output  1  port 0 request accepted this cycle
req0_src_in  input  1  1 = rs1 base, 0 = pc base
req0_pc_in  input  32  pc operand
req0_rs1_in  input  32  rs1 operand
req0_imm_in  input  32  immediate operand
req0_tag_in  input  TAG_W  requester tag
req1_valid_in, req1_ready_out, req1_src_in, req1_pc_in, req1_rs1_in, req1_imm_in, req1_tag_in  same as port 0, for port 1
iadder_pc_out  output  32  pc operand to the adder
iadder_rs1_out  output  32  rs1 operand to the adder
iadder_src_out  output  1  base select to the adder
iadder_imm_out  output  32  immediate to the adder
iadder_result_in  input  32  combinational sum from the adder
rsp_valid_out  output  1  response slot full
rsp_ready_in  input  1  consumer takes the response
rsp_result_out  output  32  registered sum
rsp_id_out  output  1  granted port (0/1)
rsp_tag_out  output  TAG_W  tag of the granted request
rsp_misaligned_out  output  1  result bit1 or bit0 nonzero (word misalignment)

Behaviour:
- Reset (rst_in low, async): state EMPTY; rsp_valid_out=0; rsp_result_out=0; rsp_id_out=0; rsp_tag_out=0; rsp_misaligned_out=0; last_grant=1, so port 0 wins the first conflict.
- FSM states: EMPTY (slot free) and FULL (slot holds an undelivered response).
- can_accept = (state==EMPTY) | (rsp_valid_out & rsp_ready_in). Drain and refill in the same cycle is allowed, which gives full throughput.
- Grant (combinational): only one valid -> that port. Both valid -> port != last_grant when FIXED_PRIO=0; port 0 when FIXED_PRIO=1. No valid -> no grant.
- reqN_ready_out = can_accept & grantN. ready depends on valid; a requester must hold its operands stable while valid & !ready.
- iadder_* outputs are muxed from the granted port. With no grant they come from port 0 (no effect on state).
- Accept edge: rsp_result_out<=iadder_result_in; rsp_id_out<=grant; rsp_tag_out<=tag; rsp_misaligned_out<=|iadder_result_in[1:0]; last_grant<=grant; state<=FULL.
- Latency: 1 cycle, from the accept edge to rsp_valid_out=1.
- FULL & !rsp_ready_in: all rsp_* outputs hold; both ready outputs are 0.
- FULL & rsp_ready_in & no request: state->EMPTY; rsp_valid_out->0; data registers keep their old values.
- Arithmetic: the 32-bit sum wraps modulo 2^32, with no carry/overflow output; wrap-around is not an error.
- last_grant updates only on an accepted transfer, never on a stall.
- If reset is asserted mid-transfer, the pending response is discarded. After reset release, arbitration restarts with port 0 preferred.

Decomposition:
- Shared package: state encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1; port id constants PORT_BR=0, PORT_LS=1.
- One sub-module: msrv32_rr_arb2 (2-way grant logic plus last_grant register, with FIXED_PRIO). The response slot stays in the top module.
- The adder itself is instantiated outside this block; the block only sequences its operands.

Test Plan:
- Reset: hold rst_in=0 with both requests valid -> all ready outputs 0, rsp_valid_out=0, all rsp data outputs 0.
- Single request: port 0 with src=0, pc=0x1000, imm=0x20, rsp_ready_in=1 -> req0_ready_out=1 in cycle N; rsp_result_out=0x1020, id=0, misaligned=0 in cycle N+1.
- Conflict round-robin: both valid every cycle, rsp_ready_in=1 -> grants alternate 0,1,0,1; port 1 with src=1, rs1=0x2003, imm=0 -> result 0x2003, misaligned=1.
- Backpressure: slot FULL, rsp_ready_in=0 for 3 cycles -> rsp outputs stable, both ready outputs 0, last_grant unchanged; raise rsp_ready_in -> same-cycle refill, rsp_valid_out stays 1.
- Wrap-around: pc=0xFFFFFFF0, imm=0x20 -> result 0x00000010, no error.
- FIXED_PRIO=1: both valid for 4 cycles -> port 0 granted every cycle, req1_ready_out stays 0.
